// File: rtl/interact_ctrl_pkg.sv
// Shared encodings for the tile interaction controller: FSM states, move
// directions, tile ids and the fixed effects the resolver applies.
package interact_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_READ    = 3'd1,
      ST_RESOLVE = 3'd2,
      ST_WRITE   = 3'd3,
      ST_FINISH  = 3'd4
   } state_t;

   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   localparam int KEYNUM_WIDTH = 8;

   // Key and door ids keep their colour index in the two low bits.
   localparam logic [15:0] TILE_GROUND    = 16'h0000;
   localparam logic [15:0] TILE_WALL      = 16'h0001;
   localparam logic [15:0] TILE_UPSTAIR   = 16'h0002;
   localparam logic [15:0] TILE_DOWNSTAIR = 16'h0003;
   localparam logic [15:0] TILE_POTION    = 16'h0004;
   localparam logic [15:0] TILE_MONSTER   = 16'h0005;
   localparam logic [15:0] TILE_KEY0      = 16'h0010;
   localparam logic [15:0] TILE_KEY1      = 16'h0011;
   localparam logic [15:0] TILE_KEY2      = 16'h0012;
   localparam logic [15:0] TILE_KEY3      = 16'h0013;
   localparam logic [15:0] TILE_DOOR0     = 16'h0020;
   localparam logic [15:0] TILE_DOOR1     = 16'h0021;
   localparam logic [15:0] TILE_DOOR2     = 16'h0022;
   localparam logic [15:0] TILE_DOOR3     = 16'h0023;

   // Arrival positions after taking a staircase.
   localparam logic [3:0] STAIR_UP_X   = 4'd5;
   localparam logic [3:0] STAIR_UP_Y   = 4'd9;
   localparam logic [3:0] STAIR_DOWN_X = 4'd5;
   localparam logic [3:0] STAIR_DOWN_Y = 4'd1;

   localparam logic [15:0] POTION_HP   = 16'd50;
   localparam logic [15:0] MONSTER_DMG = 16'd30;

endpackage

// File: rtl/interact_ctrl_mux_tiles.sv
// Combinational tile resolver: given the fetched tile and the player state,
// produces the replacement tile and the next player state. No registers.
module mux_tiles
   import interact_ctrl_pkg::*;
(
   input  logic [15:0] tile,
   input  logic [3:0]  tgt_x,
   input  logic [3:0]  tgt_y,
   input  logic [15:0] cur_floor,
   input  logic [3:0]  cur_x,
   input  logic [3:0]  cur_y,
   input  logic [31:0] cur_keys,
   input  logic [15:0] cur_health,
   output logic [15:0] new_tile,
   output logic [15:0] new_floor,
   output logic [3:0]  new_x,
   output logic [3:0]  new_y,
   output logic [31:0] new_keys,
   output logic [15:0] new_health
);

   logic [1:0]              kidx;
   logic [KEYNUM_WIDTH-1:0] kcnt;

   assign kidx = tile[1:0];
   assign kcnt = cur_keys[{kidx, 3'b000} +: KEYNUM_WIDTH];

   always_comb begin
      new_tile   = tile;
      new_floor  = cur_floor;
      new_x      = cur_x;
      new_y      = cur_y;
      new_keys   = cur_keys;
      new_health = cur_health;
      if (tile == TILE_GROUND) begin
         new_x = tgt_x;
         new_y = tgt_y;
      end else if (tile == TILE_UPSTAIR) begin
         new_floor = cur_floor + 16'd1;
         new_x     = STAIR_UP_X;
         new_y     = STAIR_UP_Y;
      end else if (tile == TILE_DOWNSTAIR) begin
         new_floor = cur_floor - 16'd1;
         new_x     = STAIR_DOWN_X;
         new_y     = STAIR_DOWN_Y;
      end else if (tile == TILE_POTION) begin
         new_health = cur_health + POTION_HP;
         new_tile   = TILE_GROUND;
         new_x      = tgt_x;
         new_y      = tgt_y;
      end else if (tile == TILE_MONSTER) begin
         // The fight clears the monster but the player keeps its square.
         new_health = cur_health - MONSTER_DMG;
         new_tile   = TILE_GROUND;
      end else if (tile[15:2] == TILE_KEY0[15:2]) begin
         new_keys[{kidx, 3'b000} +: KEYNUM_WIDTH] = kcnt + KEYNUM_WIDTH'(1);
         new_tile = TILE_GROUND;
         new_x    = tgt_x;
         new_y    = tgt_y;
      end else if (tile[15:2] == TILE_DOOR0[15:2]) begin
         if (kcnt != '0) begin
            new_keys[{kidx, 3'b000} +: KEYNUM_WIDTH] = kcnt - KEYNUM_WIDTH'(1);
            new_tile = TILE_GROUND;
            new_x    = tgt_x;
            new_y    = tgt_y;
         end
      end
   end

endmodule

// File: rtl/interact_ctrl.sv
// Move-request controller: read target tile, resolve, write back, commit player state.
// Five cycles per move (two when out of bounds); move_ready is low while a move is in flight.
module interact_ctrl
   import interact_ctrl_pkg::*;
#(
   parameter int unsigned MAP_W       = 11,
   parameter int unsigned MAP_H       = 11,
   parameter logic [15:0] INIT_FLOOR  = 16'd0,
   parameter logic [3:0]  INIT_X      = 4'd5,
   parameter logic [3:0]  INIT_Y      = 4'd10,
   parameter logic [15:0] INIT_HEALTH = 16'd100,
   parameter logic [31:0] INIT_KEYS   = 32'd0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        move_valid,
   input  logic [1:0]  move_dir,
   output logic        move_ready,
   output logic [15:0] map_floor,
   output logic [3:0]  map_x,
   output logic [3:0]  map_y,
   output logic        map_rd_en,
   input  logic [15:0] map_rd_data,
   output logic        map_wr_en,
   output logic [15:0] map_wr_data,
   output logic [15:0] floor,
   output logic [3:0]  player_x,
   output logic [3:0]  player_y,
   output logic [31:0] key_num,
   output logic [15:0] health,
   output logic        done,
   output logic        blocked
);

   localparam logic [3:0] LAST_X = 4'(MAP_W - 1);
   localparam logic [3:0] LAST_Y = 4'(MAP_H - 1);

   state_t      state;
   logic [15:0] lat_floor;
   logic [3:0]  tgt_x;
   logic [3:0]  tgt_y;
   logic [15:0] tile_q;
   logic        blocked_q;

   logic [15:0] pend_tile;
   logic [15:0] pend_floor;
   logic [3:0]  pend_x;
   logic [3:0]  pend_y;
   logic [31:0] pend_keys;
   logic [15:0] pend_health;

   logic [15:0] res_tile;
   logic [15:0] res_floor;
   logic [3:0]  res_x;
   logic [3:0]  res_y;
   logic [31:0] res_keys;
   logic [15:0] res_health;

   logic [3:0]  nxt_x;
   logic [3:0]  nxt_y;
   logic        nxt_oob;

   always_comb begin
      nxt_x   = player_x;
      nxt_y   = player_y;
      nxt_oob = 1'b0;
      case (move_dir)
         DIR_UP: begin
            nxt_oob = (player_y == 4'd0);
            nxt_y   = player_y - 4'd1;
         end
         DIR_DOWN: begin
            nxt_oob = (player_y == LAST_Y);
            nxt_y   = player_y + 4'd1;
         end
         DIR_LEFT: begin
            nxt_oob = (player_x == 4'd0);
            nxt_x   = player_x - 4'd1;
         end
         DIR_RIGHT: begin
            nxt_oob = (player_x == LAST_X);
            nxt_x   = player_x + 4'd1;
         end
         default: ;
      endcase
   end

   mux_tiles u_mux_tiles (
      .tile       (map_rd_data),
      .tgt_x      (tgt_x),
      .tgt_y      (tgt_y),
      .cur_floor  (floor),
      .cur_x      (player_x),
      .cur_y      (player_y),
      .cur_keys   (key_num),
      .cur_health (health),
      .new_tile   (res_tile),
      .new_floor  (res_floor),
      .new_x      (res_x),
      .new_y      (res_y),
      .new_keys   (res_keys),
      .new_health (res_health)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         lat_floor   <= '0;
         tgt_x       <= '0;
         tgt_y       <= '0;
         tile_q      <= '0;
         blocked_q   <= 1'b0;
         pend_tile   <= '0;
         pend_floor  <= '0;
         pend_x      <= '0;
         pend_y      <= '0;
         pend_keys   <= '0;
         pend_health <= '0;
         floor       <= INIT_FLOOR;
         player_x    <= INIT_X;
         player_y    <= INIT_Y;
         key_num     <= INIT_KEYS;
         health      <= INIT_HEALTH;
      end else begin
         case (state)
            ST_IDLE: begin
               if (move_valid) begin
                  if (nxt_oob) begin
                     blocked_q <= 1'b1;
                     state     <= ST_FINISH;
                  end else begin
                     lat_floor <= floor;
                     tgt_x     <= nxt_x;
                     tgt_y     <= nxt_y;
                     state     <= ST_READ;
                  end
               end
            end
            ST_READ: state <= ST_RESOLVE;
            ST_RESOLVE: begin
               tile_q      <= map_rd_data;
               pend_tile   <= res_tile;
               pend_floor  <= res_floor;
               pend_x      <= res_x;
               pend_y      <= res_y;
               pend_keys   <= res_keys;
               pend_health <= res_health;
               state       <= ST_WRITE;
            end
            ST_WRITE: begin
               // Compared against the old registers, which update on this same edge.
               blocked_q <= (pend_floor == floor) && (pend_x == player_x) &&
                            (pend_y == player_y);
               floor     <= pend_floor;
               player_x  <= pend_x;
               player_y  <= pend_y;
               key_num   <= pend_keys;
               health    <= pend_health;
               state     <= ST_FINISH;
            end
            ST_FINISH: state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   assign move_ready  = (state == ST_IDLE);
   assign map_rd_en   = (state == ST_READ);
   assign map_wr_en   = (state == ST_WRITE) && (pend_tile != tile_q);
   assign map_wr_data = pend_tile;
   assign map_floor   = lat_floor;
   assign map_x       = tgt_x;
   assign map_y       = tgt_y;
   assign done        = (state == ST_FINISH);
   assign blocked     = (state == ST_FINISH) && blocked_q;

endmodule

// File: tb/tb_interact_ctrl.sv
// Scoreboard bench for interact_ctrl with a synchronous map RAM model.
module tb_interact_ctrl;
   import interact_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        move_valid = 1'b0;
   logic [1:0]  move_dir = 2'd0;
   logic        move_ready;
   logic [15:0] map_floor;
   logic [3:0]  map_x, map_y;
   logic        map_rd_en;
   logic [15:0] map_rd_data = '0;
   logic        map_wr_en;
   logic [15:0] map_wr_data;
   logic [15:0] floor;
   logic [3:0]  player_x, player_y;
   logic [31:0] key_num;
   logic [15:0] health;
   logic        done, blocked;

   interact_ctrl dut (
      .clk(clk), .rst(rst), .move_valid(move_valid), .move_dir(move_dir),
      .move_ready(move_ready), .map_floor(map_floor), .map_x(map_x), .map_y(map_y),
      .map_rd_en(map_rd_en), .map_rd_data(map_rd_data), .map_wr_en(map_wr_en),
      .map_wr_data(map_wr_data), .floor(floor), .player_x(player_x),
      .player_y(player_y), .key_num(key_num), .health(health), .done(done),
      .blocked(blocked)
   );

   always #5 clk = ~clk;

   logic [15:0] mem [0:3][0:15][0:15] = '{default: '0};
   logic        pre_we = 1'b0;
   logic [1:0]  pre_f = '0;
   logic [3:0]  pre_x = '0, pre_y = '0;
   logic [15:0] pre_d = '0;

   always @(posedge clk) begin
      if (map_rd_en) map_rd_data <= mem[map_floor[1:0]][map_y][map_x];
      if (map_wr_en) mem[map_floor[1:0]][map_y][map_x] <= map_wr_data;
      if (pre_we)    mem[pre_f][pre_y][pre_x] <= pre_d;
   end

   typedef struct {
      int          lat;
      logic        blk;
      logic [15:0] flr;
      logic [3:0]  x, y;
      logic [31:0] keys;
      logic [15:0] hp;
      int          rd, wr;
      logic [15:0] wr_data, acc_floor;
      logic [3:0]  acc_x, acc_y;
   } exp_t;

   exp_t sbq[$];
   int checks = 0;
   int failures = 0;

   logic [15:0] m_floor = 16'd0;
   logic [3:0]  m_x = 4'd5, m_y = 4'd10;
   logic [31:0] m_keys = 32'd0;
   logic [15:0] m_hp = 16'd100;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [1:0] f, input logic [3:0] x, input logic [3:0] y,
                       input logic [15:0] d);
      @(negedge clk);
      pre_we = 1'b1; pre_f = f; pre_x = x; pre_y = y; pre_d = d;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   task automatic model_reset();
      m_floor = 16'd0; m_x = 4'd5; m_y = 4'd10; m_keys = 32'd0; m_hp = 16'd100;
   endtask

   task automatic do_move(input logic [1:0] dir, input bit mid_pulse);
      exp_t e, x;
      logic [3:0] tx, ty;
      logic [15:0] t, nt;
      logic oob;
      int idx, cyc, rdc, wrc, both;
      bit got;
      logic [15:0] rd_f, wd, wf;
      logic [3:0] wx, wy, rx, ry;
      logic g_blk;

      tx = m_x; ty = m_y; oob = 1'b0;
      case (dir)
         2'd0: if (m_y == 4'd0)  oob = 1'b1; else ty = m_y - 4'd1;
         2'd1: if (m_y == 4'd10) oob = 1'b1; else ty = m_y + 4'd1;
         2'd2: if (m_x == 4'd0)  oob = 1'b1; else tx = m_x - 4'd1;
         default: if (m_x == 4'd10) oob = 1'b1; else tx = m_x + 4'd1;
      endcase
      e.flr = m_floor; e.x = m_x; e.y = m_y; e.keys = m_keys; e.hp = m_hp;
      e.rd = 0; e.wr = 0; e.wr_data = '0; e.lat = 1;
      e.acc_floor = m_floor; e.acc_x = tx; e.acc_y = ty;
      if (!oob) begin
         e.lat = 4; e.rd = 1;
         t = mem[m_floor[1:0]][ty][tx];
         nt = t;
         idx = int'(t[1:0]);
         if (t == TILE_GROUND) begin
            e.x = tx; e.y = ty;
         end else if (t == TILE_UPSTAIR) begin
            e.flr = m_floor + 16'd1; e.x = 4'd5; e.y = 4'd9;
         end else if (t == TILE_DOWNSTAIR) begin
            e.flr = m_floor - 16'd1; e.x = 4'd5; e.y = 4'd1;
         end else if (t == TILE_POTION) begin
            e.hp = m_hp + 16'd50; nt = TILE_GROUND; e.x = tx; e.y = ty;
         end else if (t == TILE_MONSTER) begin
            e.hp = m_hp - 16'd30; nt = TILE_GROUND;
         end else if (t >= TILE_KEY0 && t <= TILE_KEY3) begin
            e.keys[idx*8 +: 8] = m_keys[idx*8 +: 8] + 8'd1;
            nt = TILE_GROUND; e.x = tx; e.y = ty;
         end else if (t >= TILE_DOOR0 && t <= TILE_DOOR3 && m_keys[idx*8 +: 8] != 8'd0) begin
            e.keys[idx*8 +: 8] = m_keys[idx*8 +: 8] - 8'd1;
            nt = TILE_GROUND; e.x = tx; e.y = ty;
         end
         if (nt != t) begin
            e.wr = 1; e.wr_data = nt;
         end
      end
      e.blk = (e.flr == m_floor) && (e.x == m_x) && (e.y == m_y);
      sbq.push_back(e);
      m_floor = e.flr; m_x = e.x; m_y = e.y; m_keys = e.keys; m_hp = e.hp;

      @(negedge clk);
      check_val("ready_before_move", move_ready, 1);
      move_valid = 1'b1; move_dir = dir;
      @(negedge clk);
      move_valid = 1'b0;
      cyc = 1; got = 1'b0; rdc = 0; wrc = 0; both = 0; g_blk = 1'b0;
      rd_f = '0; rx = '0; ry = '0; wd = '0; wf = '0; wx = '0; wy = '0;
      while (!got && cyc <= 20) begin
         if (map_rd_en) begin rdc++; rd_f = map_floor; rx = map_x; ry = map_y; end
         if (map_wr_en) begin wrc++; wd = map_wr_data; wf = map_floor; wx = map_x; wy = map_y; end
         if (map_rd_en && map_wr_en) both++;
         if (done) begin
            got = 1'b1; g_blk = blocked;
         end else begin
            if (mid_pulse && cyc == 2) begin
               check_val("ready_low_busy", move_ready, 0);
               move_valid = 1'b1;
            end else begin
               move_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
         end
      end
      move_valid = 1'b0;

      x = sbq.pop_front();
      check_val("done_seen", got, 1);
      check_val("done_latency", cyc, x.lat);
      check_val("blocked", g_blk, x.blk);
      check_val("floor", floor, x.flr);
      check_val("player_x", player_x, x.x);
      check_val("player_y", player_y, x.y);
      check_val("key_num", key_num, x.keys);
      check_val("health", health, x.hp);
      check_val("rd_count", rdc, x.rd);
      check_val("wr_count", wrc, x.wr);
      check_val("rd_wr_overlap", both, 0);
      if (x.rd == 1 && rdc > 0) begin
         check_val("rd_floor", rd_f, x.acc_floor);
         check_val("rd_addr", {rx, ry}, {x.acc_x, x.acc_y});
      end
      if (x.wr == 1 && wrc > 0) begin
         check_val("wr_data", wd, x.wr_data);
         check_val("wr_floor", wf, x.acc_floor);
         check_val("wr_addr", {wx, wy}, {x.acc_x, x.acc_y});
      end
      @(negedge clk);
      check_val("ready_after_done", move_ready, 1);
      check_val("done_one_cycle", done, 0);
   endtask

   initial begin
      int cyc, seen;
      poke(2'd0, 4'd5, 4'd8, TILE_WALL);
      poke(2'd0, 4'd4, 4'd9, TILE_KEY0);
      poke(2'd0, 4'd3, 4'd9, TILE_DOOR0);
      poke(2'd0, 4'd0, 4'd8, TILE_POTION);
      poke(2'd0, 4'd0, 4'd7, TILE_MONSTER);
      poke(2'd0, 4'd1, 4'd8, TILE_UPSTAIR);
      poke(2'd1, 4'd5, 4'd8, TILE_KEY1);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("rst_ready", move_ready, 1);
      check_val("rst_floor", floor, 0);
      check_val("rst_pos", {player_x, player_y}, {4'd5, 4'd10});
      check_val("rst_health", health, 100);
      check_val("rst_keys", key_num, 0);
      check_val("rst_strobes", {done, blocked, map_rd_en, map_wr_en}, 0);

      do_move(2'd0, 1'b0);   // ground
      do_move(2'd0, 1'b0);   // wall
      do_move(2'd2, 1'b0);   // key 0
      do_move(2'd2, 1'b0);   // door 0
      do_move(2'd2, 1'b0);
      do_move(2'd2, 1'b0);
      do_move(2'd2, 1'b0);   // reaches x=0
      do_move(2'd2, 1'b0);   // out of bounds
      do_move(2'd0, 1'b0);   // potion
      do_move(2'd0, 1'b0);   // monster
      do_move(2'd3, 1'b1);   // upstair with stray move_valid

      // Abort a move with reset while its write strobe is up.
      @(negedge clk);
      move_valid = 1'b1; move_dir = 2'd0;
      @(negedge clk);
      move_valid = 1'b0;
      cyc = 1;
      while (!map_wr_en && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check_val("abort_reached_write", map_wr_en, 1);
      check_val("abort_write_cycle", cyc, 3);
      rst = 1'b1;
      #1;
      check_val("abort_wr_en", map_wr_en, 0);
      check_val("abort_pos", {player_x, player_y}, {4'd5, 4'd10});
      check_val("abort_floor", floor, 0);
      check_val("abort_keys", key_num, 0);
      check_val("abort_addr", {map_floor, map_x, map_y, map_wr_data}, 0);
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i == 2) rst = 1'b0;
         if (done || map_wr_en || map_rd_en) seen++;
      end
      check_val("abort_no_activity", seen, 0);
      check_val("abort_mem_kept", mem[1][8][5], TILE_KEY1);
      model_reset();
      do_move(2'd0, 1'b0);   // fresh move after abort

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
